// File: rtl/vfpu_operand_dispatch.sv
// vfpu_operand_dispatch: pairs two buffered FP32 operand streams element by
// element and issues them one at a time to the vector FP adder, keeping at
// most one operation in flight and tracking a programmed job length.
// Optional feature macro: VFPU_DISPATCH_SCALAR_B_EN (operand B taken from a
// scalar latched at job start instead of the B stream).

// Small first-word fall-through FIFO used for each operand stream.
module vfpu_dispatch_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           count_q;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write; contents are only meaningful between push and pop.
    // NOTE: the data array is deliberately not reset -- empty/full come from the reset pointers, so stale words are never observed.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

module vfpu_operand_dispatch #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
`ifdef VFPU_DISPATCH_SCALAR_B_EN
    input  logic                  scalar_mode_i,
    input  logic [DATA_WIDTH-1:0] scalar_b_i,
`endif
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    output logic [DATA_WIDTH-1:0] operand_a_o,
    output logic [DATA_WIDTH-1:0] operand_b_o,
    output logic                  issue_o,
    input  logic                  unit_ready_i,
    input  logic                  unit_done_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  issued_cnt_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  len_q, issued_q, completed_q, acc_a_q, acc_b_q;
    logic                  outst_q, issue_q, done_q;
    logic [DATA_WIDTH-1:0] op_a_q, op_b_q;

    logic [DATA_WIDTH-1:0] a_head, b_head, b_issue_data;
    logic                  a_full, a_empty, b_full, b_empty;
    logic                  a_push, b_push, b_pop;
    logic                  scalar_en, b_avail;
    logic                  run, start_job, issue, done_eff, job_done, zero_len_done;

`ifdef VFPU_DISPATCH_SCALAR_B_EN
    logic                  scalar_mode_q;
    logic [DATA_WIDTH-1:0] scalar_b_q;

    // Scalar operand configuration, captured with each accepted start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scalar_mode_q <= 1'b0;
            scalar_b_q    <= '0;
        end else if (clear_i) begin
            scalar_mode_q <= 1'b0;
            scalar_b_q    <= '0;
        end else if (start_job) begin
            scalar_mode_q <= scalar_mode_i;
            scalar_b_q    <= scalar_b_i;
        end
    end

    assign scalar_en    = scalar_mode_q;
    assign b_issue_data = scalar_mode_q ? scalar_b_q : b_head;
`else
    assign scalar_en    = 1'b0;
    assign b_issue_data = b_head;
`endif

    assign run       = (state_q == RUN);
    assign start_job = (state_q == IDLE) && start_i;

    // Ready depends only on registered state, never on valid.
    assign a_ready_o = run && !a_full && (acc_a_q < len_q);
    assign b_ready_o = run && !b_full && (acc_b_q < len_q) && !scalar_en;
    assign a_push    = a_valid_i && a_ready_o;
    assign b_push    = b_valid_i && b_ready_o;

    // A done with nothing outstanding is spurious and ignored.
    assign done_eff  = unit_done_i && outst_q;
    assign b_avail   = scalar_en || !b_empty;
    assign issue     = run && !a_empty && b_avail && unit_ready_i &&
                       (issued_q < len_q) && (!outst_q || unit_done_i);
    assign b_pop     = issue && !scalar_en;

    assign zero_len_done = start_job && (len_i == '0);

    vfpu_dispatch_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (a_push),
        .data_i  (a_data_i),
        .pop_i   (issue),
        .head_o  (a_head),
        .full_o  (a_full),
        .empty_o (a_empty)
    );

    vfpu_dispatch_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (b_push),
        .data_i  (b_data_i),
        .pop_i   (b_pop),
        .head_o  (b_head),
        .full_o  (b_full),
        .empty_o (b_empty)
    );

    // Next-state logic: job sequencing IDLE -> RUN -> DRAIN -> IDLE.
    // NOTE: every combinational output gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d  = state_q;
        job_done = 1'b0;
        case (state_q)
            IDLE:  if (start_i && (len_i != '0)) state_d = RUN;
            RUN:   if (issue && ((issued_q + CNT_WIDTH'(1)) == len_q)) state_d = DRAIN;
            DRAIN: if (done_eff && ((completed_q + CNT_WIDTH'(1)) == len_q)) begin
                       state_d  = IDLE;
                       job_done = 1'b1;
                   end
            default: state_d = IDLE;
        endcase
    end

    // State register; clear acts like a synchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      state_q <= IDLE;
        else if (clear_i) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // Job counters: zeroed on start, never wrap inside a job since each is bounded by len.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q       <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
        end else if (clear_i) begin
            len_q       <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
        end else if (start_job) begin
            len_q       <= len_i;
            issued_q    <= '0;
            completed_q <= '0;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
        end else begin
            if (a_push)   acc_a_q     <= acc_a_q + CNT_WIDTH'(1);
            if (b_push)   acc_b_q     <= acc_b_q + CNT_WIDTH'(1);
            if (issue)    issued_q    <= issued_q + CNT_WIDTH'(1);
            if (done_eff) completed_q <= completed_q + CNT_WIDTH'(1);
        end
    end

    // Issue datapath, outstanding tracking and registered pulses to unit/controller.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outst_q <= 1'b0;
            issue_q <= 1'b0;
            done_q  <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else if (clear_i) begin
            outst_q <= 1'b0;
            issue_q <= 1'b0;
            done_q  <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            issue_q <= issue;
            done_q  <= job_done || zero_len_done;
            // Issue wins over a same-cycle done: the new op is now the outstanding one.
            if (issue)         outst_q <= 1'b1;
            else if (done_eff) outst_q <= 1'b0;
            if (issue) begin
                op_a_q <= a_head;
                op_b_q <= b_issue_data;
            end
        end
    end

    assign operand_a_o  = op_a_q;
    assign operand_b_o  = op_b_q;
    assign issue_o      = issue_q;
    assign done_o       = done_q;
    assign busy_o       = (state_q == RUN) || (state_q == DRAIN);
    assign issued_cnt_o = issued_q;
endmodule
